// File: rtl/undo_log_writer_pkg.sv
// rtl/undo_log_writer_pkg.sv - shared types, constants and address helper for the undo-log writer
package undo_log_writer_pkg;

  localparam int CQ_SLOT_W        = 4;
  localparam int UNDO_LOG_ENTRIES = 8;

  typedef logic [CQ_SLOT_W-1:0] cq_slice_slot_t;

  typedef struct packed {
    cq_slice_slot_t slot;
    logic [31:0]    data;
    logic [31:0]    addr;
  } undo_log_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B
  } ulw_state_e;

  // Each slot owns a contiguous region of `entries` 8-byte records.
  function automatic logic [63:0] log_entry_addr(input logic [63:0]    base,
                                                 input cq_slice_slot_t slot,
                                                 input logic [63:0]    idx,
                                                 input logic [63:0]    entries);
    return base + (((64'(slot) * entries) + idx) << 3);
  endfunction

endpackage

// File: rtl/undo_log_fifo.sv
// rtl/undo_log_fifo.sv - generic synchronous FIFO, power-of-two depth, push and pop in one cycle
module undo_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/undo_log_writer.sv
// rtl/undo_log_writer.sv - buffers undo records and writes them as 8-byte entries into per-slot log regions
module undo_log_writer
  import undo_log_writer_pkg::*;
#(
  parameter  int LOG_ENTRIES = UNDO_LOG_ENTRIES,
  parameter  int FIFO_DEPTH  = 4,
  localparam int CNT_W       = $clog2(LOG_ENTRIES) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             undo_log_valid,
  output logic             undo_log_ready,
  input  logic [31:0]      undo_log_addr,
  input  logic [31:0]      undo_log_data,
  input  cq_slice_slot_t   undo_log_slot,
  input  logic             clear_valid,
  input  cq_slice_slot_t   clear_slot,
  input  logic [63:0]      log_base,
  output logic             awvalid,
  input  logic             awready,
  output logic [63:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic             wvalid,
  input  logic             wready,
  output logic [63:0]      wdata,
  output logic [7:0]       wstrb,
  output logic             wlast,
  input  logic             bvalid,
  output logic             bready,
  input  logic [1:0]       bresp,
  input  cq_slice_slot_t   count_slot,
  output logic [CNT_W-1:0] count_num,
  output logic             overflow,
  output cq_slice_slot_t   overflow_slot,
  output logic             error,
  output logic             idle
);

  localparam int NUM_SLOTS = 1 << CQ_SLOT_W;
  localparam int ENTRY_W   = $bits(undo_log_entry_t);

  ulw_state_e      state_q;
  logic            init_q;
  logic            awvalid_q, wvalid_q, bready_q;
  logic [63:0]     awaddr_q, wdata_q;
  logic            overflow_q, error_q;
  cq_slice_slot_t  overflow_slot_q;
  logic [CNT_W-1:0] count_q [NUM_SLOTS];
  logic [CNT_W-1:0] count_d [NUM_SLOTS];
  logic [CNT_W-1:0] count_num_q;

  logic               fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  undo_log_entry_t    in_entry, head;
  logic [CNT_W-1:0]   head_idx;
  logic               head_full, inc, aw_done, w_done;

  assign in_entry.slot = undo_log_slot;
  assign in_entry.data = undo_log_data;
  assign in_entry.addr = undo_log_addr;

  // init_q keeps ready low until the first cycle after reset is released.
  assign undo_log_ready = init_q & ~fifo_full;
  assign push           = undo_log_valid & undo_log_ready;
  assign pop            = (state_q == ST_IDLE) & ~fifo_empty;

  undo_log_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (ENTRY_W'(in_entry)),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head      = undo_log_entry_t'(fifo_rdata);
  assign head_idx  = count_q[head.slot];
  assign head_full = (head_idx == CNT_W'(LOG_ENTRIES));
  assign inc       = pop & ~head_full;
  assign aw_done   = ~awvalid_q | awready;
  assign w_done    = ~wvalid_q | wready;

  // Clear is applied after the increment so it wins on a same-slot collision.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d[head.slot] = head_idx + CNT_W'(1);
    end
    if (clear_valid) begin
      count_d[clear_slot] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      init_q      <= 1'b0;
      count_num_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      init_q      <= 1'b1;
      count_q     <= count_d;
      count_num_q <= count_d[count_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      overflow_q      <= 1'b0;
      overflow_slot_q <= '0;
      error_q         <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (head_full) begin
              overflow_q      <= 1'b1;
              overflow_slot_q <= head.slot;
            end else begin
              awaddr_q  <= log_entry_addr(log_base, head.slot, 64'(head_idx), 64'(LOG_ENTRIES));
              wdata_q   <= {head.data, head.addr};
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (awready) begin
            awvalid_q <= 1'b0;
          end
          if (wready) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
            if (bresp != 2'b00) begin
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign awvalid       = awvalid_q;
  assign awaddr        = awaddr_q;
  assign awlen         = 8'd0;
  assign awsize        = 3'd3;
  assign wvalid        = wvalid_q;
  assign wdata         = wdata_q;
  assign wstrb         = 8'hFF;
  assign wlast         = 1'b1;
  assign bready        = bready_q;
  assign count_num     = count_num_q;
  assign overflow      = overflow_q;
  assign overflow_slot = overflow_slot_q;
  assign error         = error_q;
  assign idle          = fifo_empty & (state_q == ST_IDLE);

endmodule
